// File: rtl/cog_pkg.sv
// Shared constants for the cog pin-conditioning path.
//   SYNC_STAGES_DEF : default synchroniser depth per pin
//   FILT_BITS_DEF   : default width of the filter length and per-pin counters
//   PIN_W           : number of cog I/O pins
//   CFG_W           : width of the configuration data word
//   FLT_LSB         : bit position of the filter-length field inside data
package cog_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_BITS_DEF   = 4;
  localparam int PIN_W           = 32;
  localparam int CFG_W           = 32;
  localparam int FLT_LSB         = 0;
endpackage

// File: rtl/cog_pin_filter_if.sv
// Pin-filter bus: raw pad levels and configuration in, conditioned levels,
// edge pulses and filter-length readback out.
//   master : the side driving pads/config (counter glue or testbench)
//   slave  : the pin filter itself
interface cog_pin_filter_if
  import cog_pkg::*;
#(
  parameter int WIDTH     = PIN_W,
  parameter int FILT_BITS = FILT_BITS_DEF
);
  logic [WIDTH-1:0]     pin_raw;
  logic                 setflt;
  logic [CFG_W-1:0]     data;
  logic [WIDTH-1:0]     pin_in;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;
  logic [FILT_BITS-1:0] flt;

  modport master (output pin_raw, setflt, data,
                  input  pin_in, rise, fall, flt);
  modport slave  (input  pin_raw, setflt, data,
                  output pin_in, rise, fall, flt);
endinterface

// File: rtl/cog_pin_filter_bit.sv
// Single-pin conditioner: synchroniser chain, stability counter, filtered
// level and registered rise/fall pulses.
//   i_clk, i_rst : clock and async active-high reset
//   i_pin_raw    : asynchronous pad level
//   i_flt        : filter length L
//   o_pin_in     : filtered level
//   o_rise/o_fall: one-cycle pulses on accepted transitions
module cog_pin_filter_bit
  import cog_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_BITS   = FILT_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pin_raw,
  input  logic [FILT_BITS-1:0] i_flt,
  output logic                 o_pin_in,
  output logic                 o_rise,
  output logic                 o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_BITS-1:0]   r_cnt;
  logic                   r_pin;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sy;

  assign w_sy = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_pin  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_raw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sy == r_pin) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_flt) begin
        // >= so that lowering L mid-count releases the pending change at once
        r_pin  <= w_sy;
        r_cnt  <= '0;
        r_rise <= w_sy;
        r_fall <= ~w_sy;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pin_in = r_pin;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/cog_pin_filter.sv
// Input conditioning ahead of the cog counter: synchronises WIDTH pad levels
// into clk_cog and applies a shared programmable glitch filter per pin.
//   clk_cog : cog clock
//   res     : async active-high reset
//   bus     : slave side of cog_pin_filter_if (pin_raw/setflt/data in,
//             pin_in/rise/fall/flt out)
module cog_pin_filter
  import cog_pkg::*;
#(
  parameter int WIDTH       = PIN_W,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_BITS   = FILT_BITS_DEF
) (
  input  logic             clk_cog,
  input  logic             res,
  cog_pin_filter_if.slave  bus
);

  logic [FILT_BITS-1:0] r_flt;
  logic [WIDTH-1:0]     w_pin_in;
  logic [WIDTH-1:0]     w_rise;
  logic [WIDTH-1:0]     w_fall;
  logic                 w_unused_data;

  // Only the filter-length field of data is meaningful.
  assign w_unused_data = ^bus.data;

  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      r_flt <= '0;
    end else if (bus.setflt) begin
      r_flt <= bus.data[FLT_LSB +: FILT_BITS];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    cog_pin_filter_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_BITS   (FILT_BITS)
    ) u_bit (
      .i_clk     (clk_cog),
      .i_rst     (res),
      .i_pin_raw (bus.pin_raw[g]),
      .i_flt     (r_flt),
      .o_pin_in  (w_pin_in[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g])
    );
  end

  assign bus.pin_in = w_pin_in;
  assign bus.rise   = w_rise;
  assign bus.fall   = w_fall;
  assign bus.flt    = r_flt;

endmodule

// File: tb/tb_cog_pin_filter.sv
// Directed-vector bench for cog_pin_filter with hand-computed expectations.
module tb_cog_pin_filter;

  logic clk_cog;
  logic res;
  int   n_vec;
  int   n_err;

  cog_pin_filter_if #(.WIDTH(32), .FILT_BITS(4)) bus ();

  cog_pin_filter #(.WIDTH(32), .SYNC_STAGES(2), .FILT_BITS(4)) dut (
    .clk_cog (clk_cog),
    .res     (res),
    .bus     (bus)
  );

  initial clk_cog = 1'b0;
  always #5 clk_cog = ~clk_cog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle
  task automatic step();
    @(posedge clk_cog);
    #1;
  endtask

  task automatic do_reset();
    res         = 1'b1;
    bus.pin_raw = '0;
    bus.setflt  = 1'b0;
    bus.data    = '0;
    step();
    step();
    res = 1'b0;
    repeat (4) step();
  endtask

  task automatic set_flt(input logic [31:0] d);
    bus.data   = d;
    bus.setflt = 1'b1;
    step();
    bus.setflt = 1'b0;
    bus.data   = '0;
  endtask

  function automatic logic [31:0] pat(input int i);
    pat = (i % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
  endfunction

  initial begin
    logic [31:0] exp_v;
    logic [31:0] prev_v;
    n_vec = 0;
    n_err = 0;

    // reset with all pads high
    res         = 1'b1;
    bus.pin_raw = 32'hFFFF_FFFF;
    bus.setflt  = 1'b0;
    bus.data    = '0;
    step();
    step();
    chk("rst_pin_in", bus.pin_in, 32'h0);
    chk("rst_rise", bus.rise, 32'h0);
    chk("rst_flt", {28'h0, bus.flt}, 32'h0);
    res = 1'b0;
    step();
    chk("rel_e1_pin_in", bus.pin_in, 32'h0);
    step();
    chk("rel_e2_pin_in", bus.pin_in, 32'h0);
    step();
    chk("rel_e3_pin_in", bus.pin_in, 32'hFFFF_FFFF);
    chk("rel_e3_rise", bus.rise, 32'hFFFF_FFFF);
    chk("rel_e3_fall", bus.fall, 32'h0);
    step();
    chk("rel_e4_rise", bus.rise, 32'h0);
    chk("rel_e4_pin_in", bus.pin_in, 32'hFFFF_FFFF);

    // latency with L=0 on pin 5
    do_reset();
    bus.pin_raw = 32'h0000_0020;
    step();
    step();
    chk("lat_k1_pin_in", bus.pin_in, 32'h0);
    step();
    chk("lat_k2_pin_in", bus.pin_in, 32'h0000_0020);
    chk("lat_k2_rise", bus.rise, 32'h0000_0020);
    step();
    chk("lat_k3_rise", bus.rise, 32'h0);
    repeat (6) step();
    bus.pin_raw = 32'h0;
    step();
    step();
    chk("lat_fall_k11_pin_in", bus.pin_in, 32'h0000_0020);
    chk("lat_fall_k11_fall", bus.fall, 32'h0);
    step();
    chk("lat_fall_k12_pin_in", bus.pin_in, 32'h0);
    chk("lat_fall_k12_fall", bus.fall, 32'h0000_0020);
    step();
    chk("lat_fall_k13_fall", bus.fall, 32'h0);

    // glitch rejection with L=3 (upper data bits must be ignored)
    set_flt(32'hABCD_EF03);
    chk("flt_3", {28'h0, bus.flt}, 32'h3);
    bus.pin_raw = 32'h1;
    repeat (3) step();
    bus.pin_raw = 32'h0;
    for (int i = 0; i < 8; i++) begin
      chk("glitch3_pin_in", bus.pin_in, 32'h0);
      chk("glitch3_rise", bus.rise, 32'h0);
      step();
    end
    bus.pin_raw = 32'h1;
    for (int i = 0; i <= 9; i++) begin
      if (i == 4) bus.pin_raw = 32'h0;
      step();
      exp_v = (i >= 5 && i <= 8) ? 32'h1 : 32'h0;
      chk("pulse4_pin_in", bus.pin_in, exp_v);
      chk("pulse4_rise", bus.rise, (i == 5) ? 32'h1 : 32'h0);
      chk("pulse4_fall", bus.fall, (i == 9) ? 32'h1 : 32'h0);
    end

    // lower L mid-count on pin 9
    set_flt(32'h8);
    chk("flt_8", {28'h0, bus.flt}, 32'h8);
    bus.pin_raw = 32'h0000_0200;
    repeat (7) step();
    chk("cfg_hold_pin_in", bus.pin_in, 32'h0);
    bus.data   = 32'h2;
    bus.setflt = 1'b1;
    step();
    bus.setflt = 1'b0;
    chk("cfg_wr_pin_in", bus.pin_in, 32'h0);
    chk("flt_2", {28'h0, bus.flt}, 32'h2);
    step();
    chk("cfg_rise_pin_in", bus.pin_in, 32'h0000_0200);
    chk("cfg_rise_pulse", bus.rise, 32'h0000_0200);
    step();
    chk("cfg_rise_clear", bus.rise, 32'h0);

    // all pins toggling every cycle with L=0
    set_flt(32'h0);
    prev_v = 32'h0000_0200;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) bus.pin_raw = pat(i);
      step();
      if (i >= 2) begin
        exp_v = pat(i - 2);
        chk("alt_pin_in", bus.pin_in, exp_v);
        chk("alt_rise", bus.rise, exp_v & ~prev_v);
        chk("alt_fall", bus.fall, prev_v & ~exp_v);
        chk("alt_excl", bus.rise & bus.fall, 32'h0);
        prev_v = exp_v;
      end
    end

    // async reset while counters are running
    bus.pin_raw = 32'h0000_FFFF;
    repeat (6) step();
    chk("pre_ar_pin_in", bus.pin_in, 32'h0000_FFFF);
    set_flt(32'h5);
    bus.pin_raw = 32'hFFFF_0000;
    repeat (4) step();
    chk("mid_ar_pin_in", bus.pin_in, 32'h0000_FFFF);
    #2;
    res = 1'b1;
    #1;
    chk("ar_pin_in", bus.pin_in, 32'h0);
    chk("ar_rise", bus.rise, 32'h0);
    chk("ar_fall", bus.fall, 32'h0);
    chk("ar_flt", {28'h0, bus.flt}, 32'h0);
    step();
    res = 1'b0;
    step();
    chk("post_ar_pin_in", bus.pin_in, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
